mips_multicycle_core: RTL

Multi-cycle successor to the single-cycle MIPS datapath: one shared ALU, one register file and one unified instruction/data memory port, with the instruction split across FETCH/DECODE/EXEC/MEM/WB states. Memory is external and reached through a req/ready handshake with arbitrary wait states, so the core runs against slow or shared memories. Address width and reset vector are parametrised. Subset: add, sub, and, or, slt, addi, lw, sw, beq, j, halt.

---
 rtl/mips_multicycle_core.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core (add, sub, and, or, slt,
// addi, lw, sw, beq, j, halt) with one shared ALU, one register file and one
// unified instruction/data memory port using a req/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   mem_req    memory request valid (registered)
//   mem_we     1 = write, 0 = read (registered, valid while mem_req)
//   mem_addr   byte address, ADDR_W bits (registered, valid while mem_req)
//   mem_wdata  store data (registered, valid while mem_req && mem_we)
//   mem_rdata  read data, sampled when mem_req && mem_ready
//   mem_ready  memory completes the current request this cycle
//   halted     core stopped on a halt instruction
//   dbg_pc     current program counter
module mips_multicycle_core #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [31:0]        ir_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0]        rf_q [32];
  logic               mem_req_q, mem_we_q, halted_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;

  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd, wb_dst;
  logic [31:0]        imm_sext, addr_sum, alu_r, pc_ext, wb_data;
  logic [ADDR_W-1:0]  pc_inc, jump_pc, br_pc;
  logic               funct_ok;

  // Instruction field decode, shared ALU and target address computation
  always_comb begin
    opcode   = ir_q[31:26];
    rs       = ir_q[25:21];
    rt       = ir_q[20:16];
    rd       = ir_q[15:11];
    funct    = ir_q[5:0];
    imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    pc_ext   = 32'(pc_q);
    addr_sum = a_q + imm_sext;
    pc_inc   = pc_q + ADDR_W'(4);
    // Upper PC bits only survive when the address space reaches bit 28
    jump_pc  = ADDR_W'({pc_ext[31:28], ir_q[25:0], 2'b00});
    br_pc    = ADDR_W'(pc_ext + {imm_sext[29:0], 2'b00});
    wb_dst   = (opcode == OP_RTYPE) ? rd : rt;
    wb_data  = (opcode == OP_LW) ? mdr_q : alu_q;
    funct_ok = 1'b1;
    alu_r    = '0;
    case (funct)
      FN_ADD:  alu_r = a_q + b_q;
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = {31'b0, ($signed(a_q) < $signed(b_q))};
      default: funct_ok = 1'b0;
    endcase
  end

  // Control FSM and datapath registers; a request is launched on the edge
  // that enters FETCH or MEM so the bus sees it in the first cycle there
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_q       <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!mem_req_q) begin
            // Only after reset: no request was launched on entry
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_q;
          end else if (mem_ready) begin
            ir_q      <= mem_rdata;
            pc_q      <= pc_inc;
            mem_req_q <= 1'b0;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= rf_q[rs];
          b_q <= rf_q[rt];
          case (opcode)
            OP_J: begin
              pc_q       <= jump_pc;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= jump_pc;
              state_q    <= S_FETCH;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_q <= S_EXEC;
            default: begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= pc_q;
              state_q    <= S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              if (funct_ok) begin
                alu_q   <= alu_r;
                state_q <= S_WB;
              end else begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= pc_q;
                state_q    <= S_FETCH;
              end
            end
            OP_ADDI: begin
              alu_q   <= addr_sum;
              state_q <= S_WB;
            end
            OP_LW, OP_SW: begin
              alu_q       <= addr_sum;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (opcode == OP_SW);
              mem_addr_q  <= ADDR_W'(addr_sum);
              mem_wdata_q <= b_q;
              state_q     <= S_MEM;
            end
            OP_BEQ: begin
              if (a_q == b_q) pc_q <= br_pc;
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= (a_q == b_q) ? br_pc : pc_q;
              state_q    <= S_FETCH;
            end
            default: begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= pc_q;
              state_q    <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (mem_we_q) begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= pc_q;
              state_q    <= S_FETCH;
            end else begin
              mdr_q     <= mem_rdata;
              mem_req_q <= 1'b0;
              state_q   <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) rf_q[wb_dst] <= wb_data;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
          state_q    <= S_FETCH;
        end
        S_HALT: begin
          mem_req_q <= 1'b0;
          halted_q  <= 1'b1;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = halted_q;
  assign dbg_pc    = pc_q;

endmodule
